sound_mixer: RTL and testbench

//  Sums CH_NUM signed PCM channels into one signed output sample with saturation.

---
 rtl/sound_mixer.sv | 114 +++++++++++
 tb/tb_sound_mixer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/sound_mixer.sv
// sound_mixer: time-multiplexed saturating mixer of CH_NUM signed PCM channels.
// One adder walks the snapshotted channels one per clock after each SAMPLE_EN strobe.
module sound_mixer #(
    parameter int CH_NUM    = 4,
    parameter int IN_WIDTH  = 10,
    parameter int OUT_WIDTH = 10
) (
    input  logic                          CLK,
    input  logic                          RESET_n,
    input  logic                          SAMPLE_EN,
    input  logic [CH_NUM-1:0]             MUTE,
    input  logic [CH_NUM*IN_WIDTH-1:0]    IN,
    output logic signed [OUT_WIDTH-1:0]   OUT,
    output logic                          OUT_VALID,
    output logic                          CLIP,
    output logic                          BUSY,
    output logic                          DROPPED
);
    localparam int ACC_WIDTH = IN_WIDTH + $clog2(CH_NUM);
    localparam int IDX_W     = $clog2(CH_NUM);

    typedef enum logic [1:0] {IDLE, ACCUM, SAT} state_t;

    state_t                             state_q, state_d;
    logic signed [ACC_WIDTH-1:0]        acc_q, acc_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic [CH_NUM-1:0][IN_WIDTH-1:0]    ch_snap_q, ch_snap_d;
    logic [CH_NUM-1:0]                  mute_snap_q, mute_snap_d;
    logic signed [OUT_WIDTH-1:0]        out_q, out_d;
    logic                               valid_q, valid_d;
    logic                               clip_q, clip_d;
    logic                               dropped_q, dropped_d;
    logic signed [OUT_WIDTH-1:0]        sat_val;
    logic                               sat_clip;
    logic signed [ACC_WIDTH-1:0]        ch_ext;

    assign ch_ext = ACC_WIDTH'($signed(ch_snap_q[idx_q]));

    generate
        if (OUT_WIDTH >= ACC_WIDTH) begin : g_ext
            assign sat_val  = OUT_WIDTH'(acc_q);
            assign sat_clip = 1'b0;
        end else begin : g_clamp
            localparam logic signed [ACC_WIDTH-1:0] MAXV = ACC_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
            localparam logic signed [ACC_WIDTH-1:0] MINV = ACC_WIDTH'(-(2 ** (OUT_WIDTH - 1)));
            assign sat_val  = (acc_q > MAXV) ? OUT_WIDTH'(MAXV) :
                              (acc_q < MINV) ? OUT_WIDTH'(MINV) : OUT_WIDTH'(acc_q);
            assign sat_clip = (acc_q > MAXV) || (acc_q < MINV);
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        ch_snap_d   = ch_snap_q;
        mute_snap_d = mute_snap_q;
        out_d       = out_q;
        valid_d     = 1'b0;
        clip_d      = 1'b0;
        dropped_d   = SAMPLE_EN && (state_q != IDLE);
        case (state_q)
            IDLE: if (SAMPLE_EN) begin
                state_d     = ACCUM;
                ch_snap_d   = IN;
                mute_snap_d = MUTE;
                acc_d       = '0;
                idx_d       = '0;
            end
            ACCUM: begin
                acc_d = acc_q + (mute_snap_q[idx_q] ? '0 : ch_ext);
                idx_d = idx_q + IDX_W'(1);
                state_d = (idx_q == IDX_W'(CH_NUM - 1)) ? SAT : ACCUM;
            end
            SAT: begin
                out_d   = sat_val;
                valid_d = 1'b1;
                clip_d  = sat_clip;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            ch_snap_q   <= '0;
            mute_snap_q <= '0;
            out_q       <= '0;
            valid_q     <= 1'b0;
            clip_q      <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            ch_snap_q   <= ch_snap_d;
            mute_snap_q <= mute_snap_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
            clip_q      <= clip_d;
            dropped_q   <= dropped_d;
        end
    end

    assign OUT       = out_q;
    assign OUT_VALID = valid_q;
    assign CLIP      = clip_q;
    assign BUSY      = (state_q != IDLE);
    assign DROPPED   = dropped_q;
endmodule

// File: tb/tb_sound_mixer.sv
// tb_sound_mixer: directed and random checks of sound_mixer (10-bit and 12-bit output builds)
// against a plain-arithmetic mixing model.
module tb_sound_mixer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_en = 1'b0;
    logic [3:0]  mute = '0;
    logic [39:0] in = '0;
    logic signed [9:0]  out10;
    logic signed [11:0] out12;
    logic valid10, clip10, busy10, drop10;
    logic valid12, clip12, busy12, drop12;
    int total = 0;
    int passes = 0;

    always #5 clk = ~clk;

    sound_mixer #(.CH_NUM(4), .IN_WIDTH(10), .OUT_WIDTH(10)) dut (
        .CLK(clk), .RESET_n(rst_n), .SAMPLE_EN(sample_en), .MUTE(mute), .IN(in),
        .OUT(out10), .OUT_VALID(valid10), .CLIP(clip10), .BUSY(busy10), .DROPPED(drop10));

    sound_mixer #(.CH_NUM(4), .IN_WIDTH(10), .OUT_WIDTH(12)) dut12 (
        .CLK(clk), .RESET_n(rst_n), .SAMPLE_EN(sample_en), .MUTE(mute), .IN(in),
        .OUT(out12), .OUT_VALID(valid12), .CLIP(clip12), .BUSY(busy12), .DROPPED(drop12));

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [39:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
    endfunction

    // Reference: integer sum of unmuted channels, then clamp to the w-bit signed range.
    function automatic void model(input logic [39:0] v, input logic [3:0] m, input int w,
                                  output int o, output int c);
        int s = 0;
        int hi = (1 << (w - 1)) - 1;
        int lo = -(1 << (w - 1));
        for (int n = 0; n < 4; n++) begin
            logic [9:0] raw = v[n*10 +: 10];
            if (!m[n]) s += int'($signed(raw));
        end
        c = (s > hi || s < lo) ? 1 : 0;
        o = (s > hi) ? hi : (s < lo) ? lo : s;
    endfunction

    // Called at a negedge; strobes, scrambles inputs after the strobe edge, checks timing and result.
    task automatic run(input string tag, input logic [39:0] v, input logic [3:0] m);
        int e10, c10, e12, c12;
        int bad_busy = 0, bad_valid = 0, bad_drop = 0;
        model(v, m, 10, e10, c10);
        model(v, m, 12, e12, c12);
        in = v; mute = m; sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0; in = {$urandom, $urandom}; mute = 4'($urandom);
        for (int k = 0; k < 5; k++) begin
            if (!busy10 || !busy12) bad_busy++;
            if (valid10 || valid12 || clip10) bad_valid++;
            if (drop10 || drop12) bad_drop++;
            @(negedge clk);
        end
        chk({tag, " busy5"}, bad_busy, 0);
        chk({tag, " early_valid"}, bad_valid, 0);
        chk({tag, " dropped"}, bad_drop, 0);
        chk({tag, " valid"}, int'(valid10 & valid12), 1);
        chk({tag, " busy_end"}, int'(busy10), 0);
        chk({tag, " out10"}, int'(out10), e10);
        chk({tag, " clip10"}, int'(clip10), c10);
        chk({tag, " out12"}, int'(out12), e12);
        chk({tag, " clip12"}, int'(clip12), c12);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst out", int'(out10), 0);
        chk("rst flags", int'({valid10, clip10, busy10, drop10}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run("t1", pk(100, 200, -50, 10), 4'b0000);
        run("t2max", pk(511, 511, 511, 511), 4'b0000);
        run("t2min", pk(-512, -512, -512, -512), 4'b0000);
        run("t3mute", pk(10, 20, 30, 40), 4'b0101);
        run("t3all", pk(10, 20, 30, 40), 4'b1111);

        // Strobes during ACCUM are dropped; IN change after the strobe edge is ignored.
        in = pk(1, 2, 3, 4); mute = 4'b0000; sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0; in = pk(100, 100, 100, 100);
        @(negedge clk);
        sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        chk("t4 drop1", int'(drop10), 1);
        @(negedge clk);
        chk("t4 drop_gap", int'(drop10), 0);
        sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        chk("t4 drop2", int'(drop10), 1);
        chk("t4 no_early_valid", int'(valid10), 0);
        @(negedge clk);
        chk("t4 valid", int'(valid10), 1);
        chk("t4 out", int'(out10), 10);
        @(negedge clk);
        chk("t4 single_valid", int'({valid10, drop10, busy10}), 0);

        for (int i = 0; i < 100; i++) run("t5", {$urandom, $urandom}, 4'($urandom));

        // Asynchronous reset in the middle of ACCUM aborts the mix.
        in = pk(300, 300, 0, 0); mute = 4'b0000; sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6 busy", int'(busy10 | busy12), 0);
        chk("t6 out", int'(out10) | int'(out12), 0);
        repeat (4) begin
            @(negedge clk);
            chk("t6 no_valid", int'(valid10 | valid12), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run("t6 after", pk(-100, 7, 511, -3), 4'b0010);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
